// File: rtl/audio_playback_controller.sv
// I2S-style left-justified mono playback: fetches 16-bit samples from memory and serialises each on both channels.
// Optional build macro AUDIO_LOOP_EN: wrap to address 0 after LAST_ADDR instead of stopping in DONE.
module audio_playback_controller #(
   parameter int BCLK_HALF = 4,
   parameter int ADDR_W    = 18,
   parameter int LAST_ADDR = 240254
) (
   input  logic              clkin,
   input  logic              reset_n,
   input  logic              play,
   input  logic              stop,
   output logic [ADDR_W-1:0] mem_addr,
   input  logic [15:0]       mem_q,
   output logic              AUD_BCLK,
   output logic              AUD_DACLRCK,
   output logic              AUD_DACDAT,
   output logic              busy,
   output logic              done
);
   localparam int DW = (BCLK_HALF > 1) ? $clog2(BCLK_HALF) : 1;

   typedef enum logic [1:0] {IDLE, PRIME, PLAY, DONE} state_t;
   state_t state;

   logic [DW-1:0]     div_cnt;
   logic [5:0]        bit_idx;
   logic [15:0]       hold, shift;
   logic [1:0]        fetch_cnt;
   logic              stop_pend, last_frame;
   logic              tick, fall, frame_end, frame_start, at_last;
   logic [5:0]        nxt_idx;
   logic [15:0]       load_val;
   logic [ADDR_W-1:0] next_addr;

   always_comb begin
      tick      = (state == PLAY) && (div_cnt == DW'(BCLK_HALF - 1));
      fall      = tick && AUD_BCLK;
      frame_end = fall && (bit_idx == 6'd63);
      nxt_idx   = bit_idx + 6'd1;
      at_last   = (mem_addr == ADDR_W'(LAST_ADDR));
      // The first frame takes its sample straight from memory; later ones from the prefetch register.
      load_val  = (state == PRIME) ? mem_q : hold;
      frame_start = ((state == PRIME) && (fetch_cnt == 2'd2) && !stop) ||
                    (frame_end && !stop && !stop_pend && !last_frame);
`ifdef AUDIO_LOOP_EN
      next_addr = at_last ? '0 : mem_addr + ADDR_W'(1);
`else
      next_addr = at_last ? mem_addr : mem_addr + ADDR_W'(1);
`endif
   end

   always_ff @(posedge clkin or negedge reset_n) begin
      if (!reset_n) begin
         state       <= IDLE;
         mem_addr    <= '0;
         AUD_BCLK    <= 1'b0;
         AUD_DACLRCK <= 1'b0;
         AUD_DACDAT  <= 1'b0;
         busy        <= 1'b0;
         done        <= 1'b0;
         div_cnt     <= '0;
         bit_idx     <= '0;
         hold        <= '0;
         shift       <= '0;
         fetch_cnt   <= '0;
         stop_pend   <= 1'b0;
         last_frame  <= 1'b0;
      end else begin
         case (state)
            IDLE, DONE: begin
               if (play && !stop) begin
                  state     <= PRIME;
                  busy      <= 1'b1;
                  done      <= 1'b0;
                  mem_addr  <= '0;
                  fetch_cnt <= '0;
                  stop_pend <= 1'b0;
               end
            end
            PRIME: begin
               if (stop) begin
                  state <= IDLE;
                  busy  <= 1'b0;
               end else if (fetch_cnt == 2'd2) begin
                  state <= PLAY;
                  hold  <= mem_q;
               end else begin
                  fetch_cnt <= fetch_cnt + 2'd1;
               end
            end
            PLAY: begin
               if (stop) stop_pend <= 1'b1;
               // Prefetch: read data is sampled on the third edge after the address moved.
               if (fetch_cnt != 2'd0) begin
                  fetch_cnt <= fetch_cnt + 2'd1;
                  if (fetch_cnt == 2'd3) hold <= mem_q;
               end
               if (tick) begin
                  div_cnt  <= '0;
                  AUD_BCLK <= ~AUD_BCLK;
               end else begin
                  div_cnt <= div_cnt + DW'(1);
               end
               if (fall) begin
                  if (bit_idx == 6'd63) begin
                     if (stop || stop_pend || last_frame) begin
                        state       <= (stop || stop_pend) ? IDLE : DONE;
                        done        <= !(stop || stop_pend);
                        busy        <= 1'b0;
                        stop_pend   <= 1'b0;
                        AUD_BCLK    <= 1'b0;
                        AUD_DACLRCK <= 1'b0;
                        AUD_DACDAT  <= 1'b0;
                        div_cnt     <= '0;
                        fetch_cnt   <= '0;
                     end
                  end else begin
                     bit_idx     <= nxt_idx;
                     AUD_DACLRCK <= ~nxt_idx[5];
                     AUD_DACDAT  <= nxt_idx[4] ? 1'b0 : shift[~nxt_idx[3:0]];
                  end
               end
            end
            default: state <= IDLE;
         endcase

         if (frame_start) begin
            shift       <= load_val;
            AUD_DACDAT  <= load_val[15];
            AUD_DACLRCK <= 1'b1;
            AUD_BCLK    <= 1'b0;
            div_cnt     <= '0;
            bit_idx     <= '0;
            mem_addr    <= next_addr;
            fetch_cnt   <= 2'd1;
`ifdef AUDIO_LOOP_EN
            last_frame  <= 1'b0;
`else
            last_frame  <= at_last;
`endif
         end
      end
   end
endmodule

// File: tb/tb_audio_playback_controller.sv
// Directed bench for audio_playback_controller with LAST_ADDR=3 and a 2-cycle-latency sample memory model.
module tb_audio_playback_controller;
   localparam int ADDR_W = 18;

   logic              clkin = 1'b0;
   logic              reset_n, play, stop;
   logic [ADDR_W-1:0] mem_addr;
   logic [15:0]       mem_q = '0, q1 = '0;
   logic              AUD_BCLK, AUD_DACLRCK, AUD_DACDAT, busy, done;

   logic [15:0] mem [0:7];
   int          total = 0, bad = 0;
   int          cyc = 0, last_rise = 0, gap_bad = 0;
   logic        bclk_d = 1'b0, have_last = 1'b0, gap_en = 1'b0;

   audio_playback_controller #(.BCLK_HALF(4), .ADDR_W(ADDR_W), .LAST_ADDR(3)) dut (
      .clkin(clkin), .reset_n(reset_n), .play(play), .stop(stop),
      .mem_addr(mem_addr), .mem_q(mem_q),
      .AUD_BCLK(AUD_BCLK), .AUD_DACLRCK(AUD_DACLRCK), .AUD_DACDAT(AUD_DACDAT),
      .busy(busy), .done(done)
   );

   always #5 clkin = ~clkin;

   always @(posedge clkin) begin
      cyc    <= cyc + 1;
      q1     <= mem[mem_addr[2:0]];
      mem_q  <= q1;
      bclk_d <= AUD_BCLK;
      if (AUD_BCLK && !bclk_d) begin
         if (gap_en && have_last && (cyc - last_rise != 8)) gap_bad <= gap_bad + 1;
         last_rise <= cyc;
         have_last <= gap_en;
      end
   end

   task automatic chk(input string tag, input logic [63:0] obs, input logic [63:0] exp);
      total++;
      assert (obs === exp) else begin
         bad++;
         $error("FAIL %s observed=%0h expected=%0h", tag, obs, exp);
      end
   endtask

   // Samples DACDAT/LRCK on each of the next 64 BCLK rising edges.
   task automatic capture_frame(output logic [63:0] d, output logic [63:0] l,
                                output logic [ADDR_W-1:0] a0, output logic ok);
      int n;
      ok = 1'b1; d = '0; l = '0; a0 = '0;
      for (int i = 0; i < 64; i++) begin
         n = 0;
         do begin
            @(negedge clkin);
            n++;
         end while (!(AUD_BCLK && !bclk_d) && n < 200);
         if (n >= 200) begin
            ok = 1'b0;
            return;
         end
         d[63-i] = AUD_DACDAT;
         l[63-i] = AUD_DACLRCK;
         if (i == 0) a0 = mem_addr;
      end
   endtask

   task automatic check_frame(input string tag, input int sidx, input int eaddr);
      logic [63:0]       d, l;
      logic [ADDR_W-1:0] a0;
      logic              ok;
      capture_frame(d, l, a0, ok);
      chk({tag, "_ok"}, 64'(ok), 64'd1);
      chk({tag, "_dat"}, d, {mem[sidx], 16'h0, mem[sidx], 16'h0});
      chk({tag, "_lrck"}, l, {32'hFFFF_FFFF, 32'h0});
      chk({tag, "_addr"}, 64'(a0), 64'(eaddr));
   endtask

   task automatic outs_zero(input string tag);
      chk({tag, "_bclk"}, 64'(AUD_BCLK), 64'd0);
      chk({tag, "_lrck"}, 64'(AUD_DACLRCK), 64'd0);
      chk({tag, "_dat"}, 64'(AUD_DACDAT), 64'd0);
      chk({tag, "_busy"}, 64'(busy), 64'd0);
   endtask

   task automatic pulse_play();
      play = 1'b1;
      @(negedge clkin);
      play = 1'b0;
   endtask

   initial begin
      int n, rises;
      mem[0] = 16'hA5C3; mem[1] = 16'h1234; mem[2] = 16'hFFFF; mem[3] = 16'h8001;
      mem[4] = 16'h0F0F; mem[5] = 16'h5555; mem[6] = 16'hAAAA; mem[7] = 16'h7E81;
      reset_n = 1'b0; play = 1'b0; stop = 1'b0;

      repeat (3) @(negedge clkin);
      outs_zero("reset");
      chk("reset_done", 64'(done), 64'd0);
      chk("reset_addr", 64'(mem_addr), 64'd0);

      @(negedge clkin) reset_n = 1'b1;
      repeat (20) @(negedge clkin);
      chk("no_autostart", 64'(busy), 64'd0);

      play = 1'b1; stop = 1'b1;
      @(negedge clkin);
      play = 1'b0; stop = 1'b0;
      repeat (5) @(negedge clkin);
      chk("play_stop_busy", 64'(busy), 64'd0);
      chk("play_stop_bclk", 64'(AUD_BCLK), 64'd0);

      // Stop during PRIME returns straight to idle.
      pulse_play();
      stop = 1'b1;
      @(negedge clkin);
      stop = 1'b0;
      @(negedge clkin);
      chk("prime_stop_busy", 64'(busy), 64'd0);

      gap_en = 1'b1;
      pulse_play();
      chk("play_busy", 64'(busy), 64'd1);
      check_frame("f0", 0, 1);
      check_frame("f1", 1, 2);
      check_frame("f2", 2, 3);
`ifdef AUDIO_LOOP_EN
      check_frame("f3", 3, 0);
      check_frame("f4", 0, 1);
      check_frame("f5", 1, 2);
      chk("loop_busy", 64'(busy), 64'd1);
      chk("loop_done", 64'(done), 64'd0);
`else
      check_frame("f3", 3, 3);
      n = 0;
      while (!done && n < 100) begin
         @(negedge clkin);
         n++;
      end
      chk("done_reached", 64'(done), 64'd1);
      outs_zero("done");
      chk("done_addr_hold", 64'(mem_addr), 64'd3);
`endif
      gap_en = 1'b0;
      chk("bclk_gap", 64'(gap_bad), 64'd0);

      // Asynchronous reset in the middle of a frame.
      pulse_play();
      repeat (100) @(negedge clkin);
      #2 reset_n = 1'b0;
      #1;
      outs_zero("async_rst");
      chk("async_rst_addr", 64'(mem_addr), 64'd0);
      chk("async_rst_done", 64'(done), 64'd0);
      @(negedge clkin) reset_n = 1'b1;
      repeat (5) @(negedge clkin);

      // Stop at BCLK 20 of frame 2; a play pulse while busy must be ignored.
      pulse_play();
      check_frame("s0", 0, 1);
      pulse_play();
      check_frame("s1", 1, 2);
      rises = 0; n = 0;
      while (busy && n < 3000) begin
         @(negedge clkin);
         n++;
         stop = 1'b0;
         if (AUD_BCLK && !bclk_d) begin
            rises++;
            if (rises == 21) stop = 1'b1;
         end
      end
      stop = 1'b0;
      chk("stop_timeout", 64'(n < 3000), 64'd1);
      chk("stop_frame_bclks", 64'(rises), 64'd64);
      repeat (3) @(negedge clkin);
      outs_zero("stop_idle");
      chk("stop_done", 64'(done), 64'd0);
      chk("stop_addr_hold", 64'(mem_addr), 64'd3);

      $display("test done: total=%0d bad=%0d", total, bad);
      $finish;
   end
endmodule
